instr_encoder: RTL and testbench

Assembles symbolic MIPS instructions (mnemonic plus register/immediate fields) into 32-bit machine words and streams them into instruction memory through a write port. It produces the same opcode/funct encodings that the core's control decoder consumes. It sits between the testbench/boot loader front end and the instruction memory, and is used to load programs before the core is released from reset.

---
 rtl/instr_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Assembles symbolic MIPS instructions into 32-bit words and streams them into instruction memory.
// Optional feature: ENC_DELAY_SLOT_PAD_EN inserts a NOP word after every branch or jump.
module instr_encoder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [4:0]        i_mnem,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_err_illegal,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W:0] LastAddr = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DepthW   = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
`ifdef ENC_DELAY_SLOT_PAD_EN
    StPad,
`endif
    StFinish
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic                r_overflow;
  logic                r_err_illegal;

  logic                w_accept;
  logic                w_legal;
  logic [31:0]         w_word;
  logic                w_ptr_at_end;
  logic                w_ptr_oob;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] funct);
    return {6'd0, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (i_mnem)
      5'd0:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd33);
      5'd1:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd35);
      5'd2:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd36);
      5'd3:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd37);
      5'd4:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd38);
      5'd5:    w_word = rtype(i_rs, i_rt, i_rd, i_shamt, 6'd43);
      5'd6:    w_word = rtype(5'd0, i_rt, i_rd, i_shamt, 6'd0);
      5'd7:    w_word = rtype(5'd0, i_rt, i_rd, i_shamt, 6'd2);
      5'd8:    w_word = rtype(i_rs, 5'd0, 5'd0, 5'd0, 6'd8);
      5'd9:    w_word = itype(6'd9, i_rs, i_rt, i_imm);
      5'd10:   w_word = itype(6'd12, i_rs, i_rt, i_imm);
      5'd11:   w_word = itype(6'd13, i_rs, i_rt, i_imm);
      5'd12:   w_word = itype(6'd11, i_rs, i_rt, i_imm);
      5'd13:   w_word = itype(6'd15, 5'd0, i_rt, i_imm);
      5'd14:   w_word = itype(6'd4, i_rs, i_rt, i_imm);
      5'd15:   w_word = itype(6'd5, i_rs, i_rt, i_imm);
      5'd16:   w_word = itype(6'd35, i_rs, i_rt, i_imm);
      5'd17:   w_word = itype(6'd43, i_rs, i_rt, i_imm);
      5'd18:   w_word = {6'd2, i_target};
      5'd19:   w_word = {6'd3, i_target};
      default: w_legal = 1'b0;
    endcase
  end

  assign o_in_ready   = (r_state == StLoad);
  assign w_accept     = i_in_valid & o_in_ready;
  assign w_ptr_at_end = ({1'b0, r_ptr} == LastAddr);
  assign w_ptr_oob    = ({1'b0, r_ptr} >= DepthW);

`ifdef ENC_DELAY_SLOT_PAD_EN
  logic w_branch;
  logic r_pad_last;
  assign w_branch = (i_mnem == 5'd8) | (i_mnem == 5'd14) | (i_mnem == 5'd15) |
                    (i_mnem == 5'd18) | (i_mnem == 5'd19);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_ptr         <= '0;
      r_word_count  <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_overflow    <= 1'b0;
      r_err_illegal <= 1'b0;
`ifdef ENC_DELAY_SLOT_PAD_EN
      r_pad_last    <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_ptr         <= i_base_addr;
            r_word_count  <= '0;
            r_overflow    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_state       <= StLoad;
          end
        end
        StLoad: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_err_illegal <= 1'b1;
              if (i_in_last) r_state <= StFinish;
            end else if (w_ptr_oob) begin
              r_overflow <= 1'b1;
              r_state    <= StFinish;
            end else begin
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_ptr;
              r_wr_data    <= w_word;
              r_word_count <= r_word_count + 1'b1;
              // Pointer saturates at the last word; the session ends there anyway.
              if (!w_ptr_at_end) r_ptr <= r_ptr + 1'b1;
`ifdef ENC_DELAY_SLOT_PAD_EN
              r_pad_last <= i_in_last;
              if (w_branch && !w_ptr_at_end) begin
                r_state <= StPad;
              end else if (w_ptr_at_end && (w_branch || !i_in_last)) begin
                r_overflow <= 1'b1;
                r_state    <= StFinish;
              end else if (i_in_last) begin
                r_state <= StFinish;
              end
`else
              if (w_ptr_at_end && !i_in_last) begin
                r_overflow <= 1'b1;
                r_state    <= StFinish;
              end else if (i_in_last) begin
                r_state <= StFinish;
              end
`endif
            end
          end
        end
`ifdef ENC_DELAY_SLOT_PAD_EN
        StPad: begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_ptr;
          r_wr_data    <= 32'h0000_0000;
          r_word_count <= r_word_count + 1'b1;
          if (!w_ptr_at_end) r_ptr <= r_ptr + 1'b1;
          if (w_ptr_at_end && !r_pad_last) begin
            r_overflow <= 1'b1;
            r_state    <= StFinish;
          end else if (r_pad_last) begin
            r_state <= StFinish;
          end else begin
            r_state <= StLoad;
          end
        end
`endif
        StFinish: r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StFinish);
  assign o_overflow    = r_overflow;
  assign o_err_illegal = r_err_illegal;
  assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed machine words.
// Builds with or without ENC_DELAY_SLOT_PAD_EN; the branch step adapts to the macro.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  mnem, rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, overflow, err_illegal;
  logic [8:0]  word_count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(.DEPTH(256), .ADDR_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_last    (in_last),
    .i_mnem       (mnem),
    .i_rs         (rs),
    .i_rt         (rt),
    .i_rd         (rd),
    .i_shamt      (shamt),
    .i_imm        (imm),
    .i_target     (target),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_err_illegal(err_illegal),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [31:0] d);
    chk({tag, ".wr_en"}, {31'd0, wr_en}, 32'd1);
    chk({tag, ".addr"}, {24'd0, wr_addr}, {24'd0, a});
    chk({tag, ".data"}, wr_data, d);
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                      input logic [25:0] tg, input logic last);
    in_valid = 1'b1;
    mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg; in_last = last;
  endtask

  task automatic open_session(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    tick();
    tick();
    chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.count", {23'd0, word_count}, 32'd0);
    rst = 1'b0;

    // ADDU then ADDIU (last) at 0x10
    open_session(8'h10);
    chk("s1.busy", {31'd0, busy}, 32'd1);
    chk("s1.ready", {31'd0, in_ready}, 32'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk_wr("s1.addu", 8'h10, 32'h0022_1821);
    chk("s1.done0", {31'd0, done}, 32'd0);
    send(5'd9, 5'd0, 5'd4, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1);
    tick();
    chk_wr("s1.addiu", 8'h11, 32'h2404_0005);
    chk("s1.done", {31'd0, done}, 32'd1);
    chk("s1.ready_drop", {31'd0, in_ready}, 32'd0);
    chk("s1.count", {23'd0, word_count}, 32'd2);
    in_valid = 1'b0;
    tick();
    chk("s1.idle_wr", {31'd0, wr_en}, 32'd0);
    chk("s1.idle_busy", {31'd0, busy}, 32'd0);
    chk("s1.done_pulse", {31'd0, done}, 32'd0);

    // SLL (rs forced to 0), LUI, J back to back
    open_session(8'h20);
    send(5'd6, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    tick();
    chk_wr("s2.sll", 8'h20, 32'h0001_1100);
    send(5'd13, 5'd9, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    tick();
    chk_wr("s2.lui", 8'h21, 32'h3C08_1234);
    send(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b1);
    tick();
    chk_wr("s2.j", 8'h22, 32'h0800_0100);
    chk("s2.done", {31'd0, done}, 32'd1);
    in_valid = 1'b0;
    tick();

    // BEQ then ORI at 0x00
    open_session(8'h00);
    send(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    tick();
    chk_wr("s3.beq", 8'h00, 32'h1022_FFFF);
    send(5'd11, 5'd3, 5'd5, 5'd0, 5'd0, 16'h00F0, 26'h0, 1'b1);
`ifdef ENC_DELAY_SLOT_PAD_EN
    chk("s3.ready_pad", {31'd0, in_ready}, 32'd0);
    tick();
    chk_wr("s3.pad", 8'h01, 32'h0000_0000);
    chk("s3.ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk_wr("s3.ori", 8'h02, 32'h3465_00F0);
    chk("s3.count", {23'd0, word_count}, 32'd3);
`else
    chk("s3.ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_wr("s3.ori", 8'h01, 32'h3465_00F0);
    chk("s3.count", {23'd0, word_count}, 32'd2);
`endif
    chk("s3.done", {31'd0, done}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Illegal mnemonic mid-stream
    open_session(8'h30);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk_wr("s4.addu", 8'h30, 32'h0022_1821);
    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk("s4.ill_nowr", {31'd0, wr_en}, 32'd0);
    chk("s4.ill_err", {31'd0, err_illegal}, 32'd1);
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    chk_wr("s4.subu", 8'h31, 32'h0022_1823);
    chk("s4.count", {23'd0, word_count}, 32'd2);
    chk("s4.err_sticky", {31'd0, err_illegal}, 32'd1);
    in_valid = 1'b0;
    tick();
    open_session(8'h50);
    chk("s4.err_clr", {31'd0, err_illegal}, 32'd0);
    chk("s4.count_clr", {23'd0, word_count}, 32'd0);
    send(5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();

    // Overflow at the top of memory
    open_session(8'd254);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk_wr("s5.w254", 8'd254, 32'h0022_1821);
    chk("s5.ovf0", {31'd0, overflow}, 32'd0);
    tick();
    chk_wr("s5.w255", 8'd255, 32'h0022_1821);
    chk("s5.ovf", {31'd0, overflow}, 32'd1);
    chk("s5.done", {31'd0, done}, 32'd1);
    chk("s5.ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("s5.third_nowr", {31'd0, wr_en}, 32'd0);
    chk("s5.count", {23'd0, word_count}, 32'd2);
    chk("s5.idle", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    tick();

    // Reset alongside an accept, then reset with a write pending
    open_session(8'h40);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    rst = 1'b1;
    tick();
    chk("s6.nowr", {31'd0, wr_en}, 32'd0);
    chk("s6.busy", {31'd0, busy}, 32'd0);
    chk("s6.ovf", {31'd0, overflow}, 32'd0);
    chk("s6.data", wr_data, 32'd0);
    chk("s6.addr", {24'd0, wr_addr}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    open_session(8'h40);
    chk("s6.restart", {31'd0, busy}, 32'd1);
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk_wr("s6.and", 8'h40, 32'h0022_1824);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("s6.mid_wr", {31'd0, wr_en}, 32'd0);
    chk("s6.mid_count", {23'd0, word_count}, 32'd0);
    chk("s6.mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    open_session(8'h00);
    chk("s6.start_after", {31'd0, busy}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
